// File: rtl/timer_ctrl_pkg.sv
// Shared timer definitions: FSM state encoding used by timer_ctrl.
// The guard allows this file to be pulled in more than once.
`ifndef TIMER_CTRL_PKG_SV
`define TIMER_CTRL_PKG_SV
package timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10
  } state_e;

endpackage
`endif

// File: rtl/timer_ctrl_counter.sv
// tc_counter: N-bit up counter with async active-low reset, synchronous clear
// (priority over enable) and count enable. Wraps modulo 2^N.
module tc_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [N-1:0] count_o
);

  // Count register: clear beats enable, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_o <= '0;
    end else if (clr_i) begin
      count_o <= '0;
    end else if (en_i) begin
      count_o <= count_o + {{(N-1){1'b0}}, 1'b1};
    end else begin
      count_o <= count_o;
    end
  end

endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: one-shot / auto-reload timer. FSM, limit/mode latches, terminal
// compare and the registered done/busy outputs; the count lives in tc_counter.
module timer_ctrl
  import timer_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic         periodic,
  input  logic [N-1:0] limit,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done
);

  state_e         state_q, state_d;
  logic [N-1:0]   lim_q, lim_d;
  logic           per_q, per_d;
  logic           done_q, done_d;
  logic           busy_q;
  logic           cnt_clr;
  logic           cnt_en;
  logic           at_limit;

  assign at_limit = (count == lim_q);
  assign busy     = busy_q;
  assign done     = done_q;

  tc_counter #(.N(N)) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (cnt_clr),
    .en_i    (cnt_en),
    .count_o (count)
  );

  // Next-state, latch and counter-control decode; stop always beats start.
  always_comb begin
    state_d = state_q;
    lim_d   = lim_q;
    per_d   = per_q;
    done_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (start && !stop) begin
          lim_d   = limit;
          per_d   = periodic;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (stop) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (at_limit) begin
          done_d = 1'b1;
          if (per_q) begin
            cnt_clr = 1'b1;
            state_d = RUN;
          end else begin
            state_d = HOLD;
          end
        end else begin
          cnt_en = 1'b1;
        end
      end
      HOLD: begin
        if (stop) begin
          cnt_clr = 1'b1;
          state_d = IDLE;
        end else if (start) begin
          lim_d   = limit;
          per_d   = periodic;
          cnt_clr = 1'b1;
          state_d = RUN;
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // State, latches and registered outputs; busy mirrors the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lim_q   <= '0;
      per_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lim_q   <= lim_d;
      per_q   <= per_d;
      done_q  <= done_d;
      busy_q  <= (state_d == RUN);
    end
  end

endmodule

// File: tb/tb_timer_ctrl.sv
// Self-checking bench for timer_ctrl: a run-time-index model predicts every
// cycle, and directed vectors pin literal expectations.
module tb_timer_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         periodic = 1'b0;
  logic [N-1:0] limit = '0;
  logic [N-1:0] count;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  timer_ctrl #(.N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .limit    (limit),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_t = edges since the run started; outputs follow from arithmetic on it.
  bit m_act;
  int m_t;
  int m_L;
  bit m_P;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0;
      m_t   <= 0;
      m_L   <= 0;
      m_P   <= 1'b0;
    end else if (!m_act) begin
      if (start && !stop) begin
        m_act <= 1'b1;
        m_t   <= 0;
        m_L   <= int'(limit);
        m_P   <= periodic;
      end
    end else if (stop) begin
      m_act <= 1'b0;
    end else if (!m_P && m_t > m_L && start) begin
      m_t <= 0;
      m_L <= int'(limit);
      m_P <= periodic;
    end else begin
      m_t <= m_t + 1;
    end
  end

  function automatic int exp_count();
    if (!m_act) return 0;
    if (m_P) return m_t % (m_L + 1);
    return (m_t < m_L) ? m_t : m_L;
  endfunction

  function automatic int exp_done();
    if (!m_act || m_t < 1) return 0;
    if (m_P) return ((m_t % (m_L + 1)) == 0) ? 1 : 0;
    return (m_t == m_L + 1) ? 1 : 0;
  endfunction

  function automatic int exp_busy();
    return (m_act && (m_P || m_t <= m_L)) ? 1 : 0;
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_count", 32'(count), exp_count());
      chk("model_done", 32'(done), exp_done());
      chk("model_busy", 32'(busy), exp_busy());
    end
  end

  task automatic pulse_start(input int lim, input bit per);
    start    = 1'b1;
    limit    = lim[N-1:0];
    periodic = per;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  int os_cnt [6]  = '{0, 1, 2, 3, 3, 3};
  int os_done[6]  = '{0, 0, 0, 0, 1, 0};
  int os_busy[6]  = '{1, 1, 1, 1, 0, 0};
  int pe_cnt [7]  = '{0, 1, 2, 0, 1, 2, 0};
  int pe_done[7]  = '{0, 0, 0, 1, 0, 0, 1};
  int z_done [4]  = '{0, 1, 1, 1};

  initial begin
    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);
    chk("reset_count", 32'(count), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // start together with stop stays idle
    start = 1'b1;
    stop  = 1'b1;
    limit = 4'd3;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_idle_busy", 32'(busy), 0);

    // one-shot, limit 3
    pulse_start(3, 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("oneshot_count", 32'(count), os_cnt[i]);
      chk("oneshot_done", 32'(done), os_done[i]);
      chk("oneshot_busy", 32'(busy), os_busy[i]);
      @(negedge clk);
    end

    // restart from HOLD with limit 7
    pulse_start(7, 1'b0);
    repeat (7) @(negedge clk);
    chk("restart_count7", 32'(count), 7);
    chk("restart_done_early", 32'(done), 0);
    @(negedge clk);
    chk("restart_done", 32'(done), 1);
    chk("restart_hold", 32'(count), 7);
    pulse_stop();
    chk("hold_stop_count", 32'(count), 0);

    // periodic, limit 2; a start mid-run must be ignored
    pulse_start(2, 1'b1);
    for (int i = 0; i < 7; i++) begin
      chk("periodic_count", 32'(count), pe_cnt[i]);
      chk("periodic_done", 32'(done), pe_done[i]);
      chk("periodic_busy", 32'(busy), 1);
      start = (i == 1);
      limit = (i == 1) ? 4'd9 : 4'd2;
      periodic = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    pulse_stop();

    // stop on the terminal edge suppresses done
    pulse_start(5, 1'b0);
    repeat (5) @(negedge clk);
    chk("collide_pre_count", 32'(count), 5);
    pulse_stop();
    chk("collide_done", 32'(done), 0);
    chk("collide_count", 32'(count), 0);
    chk("collide_busy", 32'(busy), 0);
    @(negedge clk);
    chk("collide_no_late_done", 32'(done), 0);

    // async reset mid-run
    pulse_start(9, 1'b0);
    repeat (6) @(negedge clk);
    chk("async_pre_count", 32'(count), 6);
    #2 rst_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 0);
    chk("async_busy", 32'(busy), 0);
    chk("async_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("after_reset_busy", 32'(busy), 0);

    // limit 0 periodic: done every cycle
    pulse_start(0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("zero_count", 32'(count), 0);
      chk("zero_done", 32'(done), z_done[i]);
      @(negedge clk);
    end
    pulse_stop();

    // limit 15 one-shot: no wrap
    pulse_start(15, 1'b0);
    repeat (15) @(negedge clk);
    chk("max_count", 32'(count), 15);
    chk("max_busy", 32'(busy), 1);
    chk("max_done_early", 32'(done), 0);
    @(negedge clk);
    chk("max_done", 32'(done), 1);
    chk("max_hold", 32'(count), 15);
    chk("max_busy_low", 32'(busy), 0);
    @(negedge clk);
    chk("max_done_once", 32'(done), 0);
    chk("max_no_wrap", 32'(count), 15);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
